// File: rtl/add_float_pipe.sv
// add_float_pipe: three-stage pipelined floating-point adder/subtractor.
// Stage 1 unpacks, classifies, swaps and aligns; stage 2 adds or subtracts
// the aligned significands; stage 3 normalises, rounds, packs and raises
// flags. Denormal inputs and results are flushed to zero. All stages advance
// together on adv = !out_valid || out_ready.
// Build option: define ADD_FLOAT_RNE_EN for round-to-nearest-even; without it
// the result is truncated (round toward zero).
module add_float_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   a,
    input  logic [EXP_W+MANT_W:0]   b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   sum,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    invalid
);

    localparam int W   = 1 + EXP_W + MANT_W;
    localparam int FW  = MANT_W + 4;            // hidden + mantissa + G,R,S
    localparam int SW  = MANT_W + 5;            // FW plus carry
    localparam int XW  = EXP_W + 8;             // signed exponent headroom
    localparam int LZW = $clog2(FW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [31:0]      ALIGN_LIM = 32'(MANT_W + 3);
    localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX_X = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0] ZERO_X    = {XW{1'b0}};
    localparam logic signed [XW-1:0] ONE_X     = {{(XW-1){1'b0}}, 1'b1};
`ifdef ADD_FLOAT_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    // Leading-zero count of a normalisation field (FW when the field is zero).
    function automatic logic [LZW-1:0] lzc_f(input logic [FW-1:0] v);
        logic [LZW-1:0] cnt;
        logic           found;
        cnt   = {LZW{1'b0}};
        found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (found || v[i]) begin
                found = 1'b1;
            end else begin
                cnt = cnt + {{(LZW-1){1'b0}}, 1'b1};
            end
        end
        return cnt;
    endfunction

    // ---------------- global advance ----------------
    logic adv_s;
    logic out_valid_q;
    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = adv_s && rst_n;

    // ---------------- stage 1 combinational ----------------
    logic                sign_a_s, sign_b_s;
    logic [EXP_W-1:0]    exp_a_s, exp_b_s;
    logic [MANT_W-1:0]   mant_a_s, mant_b_s;
    logic                zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
    logic [EXP_W+MANT_W-1:0] mag_a_s, mag_b_s;

    assign sign_a_s = a[W-1];
    assign sign_b_s = b[W-1] ^ sub;
    assign exp_a_s  = a[W-2:MANT_W];
    assign exp_b_s  = b[W-2:MANT_W];
    assign mant_a_s = a[MANT_W-1:0];
    assign mant_b_s = b[MANT_W-1:0];
    assign zero_a_s = (exp_a_s == {EXP_W{1'b0}});
    assign zero_b_s = (exp_b_s == {EXP_W{1'b0}});
    assign inf_a_s  = (exp_a_s == EXP_ONES) && (mant_a_s == {MANT_W{1'b0}});
    assign inf_b_s  = (exp_b_s == EXP_ONES) && (mant_b_s == {MANT_W{1'b0}});
    assign nan_a_s  = (exp_a_s == EXP_ONES) && (mant_a_s != {MANT_W{1'b0}});
    assign nan_b_s  = (exp_b_s == EXP_ONES) && (mant_b_s != {MANT_W{1'b0}});
    assign mag_a_s  = zero_a_s ? {(EXP_W+MANT_W){1'b0}} : {exp_a_s, mant_a_s};
    assign mag_b_s  = zero_b_s ? {(EXP_W+MANT_W){1'b0}} : {exp_b_s, mant_b_s};

    logic                swap_s, sign_big_s, sign_sm_s, zero_big_s, zero_sm_s;
    logic [EXP_W-1:0]    exp_big_s, exp_sm_s, diff_s;
    logic [MANT_W-1:0]   mant_big_s, mant_sm_s;
    logic [FW-1:0]       big_field_s, small_field_s;
    logic [2*FW-1:0]     wide_s;

    // Order operands by magnitude and align the smaller one with sticky.
    always_comb begin
        swap_s = (mag_b_s > mag_a_s);
        if (swap_s) begin
            sign_big_s = sign_b_s;  exp_big_s = exp_b_s;  mant_big_s = mant_b_s;  zero_big_s = zero_b_s;
            sign_sm_s  = sign_a_s;  exp_sm_s  = exp_a_s;  mant_sm_s  = mant_a_s;  zero_sm_s  = zero_a_s;
        end else begin
            sign_big_s = sign_a_s;  exp_big_s = exp_a_s;  mant_big_s = mant_a_s;  zero_big_s = zero_a_s;
            sign_sm_s  = sign_b_s;  exp_sm_s  = exp_b_s;  mant_sm_s  = mant_b_s;  zero_sm_s  = zero_b_s;
        end
        diff_s = exp_big_s - exp_sm_s;
        if (zero_big_s) begin
            big_field_s = {FW{1'b0}};
        end else begin
            big_field_s = {1'b1, mant_big_s, 3'b000};
        end
        wide_s = {1'b1, mant_sm_s, 3'b000, {FW{1'b0}}} >> diff_s;
        if (zero_sm_s) begin
            small_field_s = {FW{1'b0}};
        end else if (32'(diff_s) >= ALIGN_LIM) begin
            small_field_s = {{(FW-1){1'b0}}, 1'b1};
        end else begin
            small_field_s = {wide_s[2*FW-1:FW+1], wide_s[FW] | (|wide_s[FW-1:0])};
        end
    end

    logic           spec_s, spec_inv_s;
    logic [W-1:0]   spec_res_s;

    // Classify NaN/infinity operands into a bypass result.
    always_comb begin
        if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (sign_a_s != sign_b_s))) begin
            spec_s = 1'b1;  spec_inv_s = 1'b0;  spec_res_s = QNAN;
            spec_inv_s = 1'b1;
        end else if (inf_a_s) begin
            spec_s = 1'b1;  spec_inv_s = 1'b0;  spec_res_s = {sign_a_s, EXP_ONES, {MANT_W{1'b0}}};
        end else if (inf_b_s) begin
            spec_s = 1'b1;  spec_inv_s = 1'b0;  spec_res_s = {sign_b_s, EXP_ONES, {MANT_W{1'b0}}};
        end else begin
            spec_s = 1'b0;  spec_inv_s = 1'b0;  spec_res_s = {W{1'b0}};
        end
    end

    // ---------------- stage 1 registers ----------------
    logic               s1_valid_q, s1_spec_q, s1_inv_q, s1_sign_q, s1_eff_sub_q, s1_zsign_q;
    logic [W-1:0]       s1_spec_res_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [FW-1:0]      s1_big_q, s1_small_q;

    // Capture the unpacked and aligned operand pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_inv_q      <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_eff_sub_q  <= 1'b0;
            s1_zsign_q    <= 1'b0;
            s1_spec_res_q <= {W{1'b0}};
            s1_exp_q      <= {EXP_W{1'b0}};
            s1_big_q      <= {FW{1'b0}};
            s1_small_q    <= {FW{1'b0}};
        end else if (adv_s) begin
            s1_valid_q    <= in_valid;
            s1_spec_q     <= spec_s;
            s1_inv_q      <= spec_inv_s;
            s1_sign_q     <= sign_big_s;
            s1_eff_sub_q  <= sign_big_s ^ sign_sm_s;
            s1_zsign_q    <= zero_a_s & zero_b_s & sign_a_s & sign_b_s;
            s1_spec_res_q <= spec_res_s;
            s1_exp_q      <= exp_big_s;
            s1_big_q      <= big_field_s;
            s1_small_q    <= small_field_s;
        end
    end

    // ---------------- stage 2 ----------------
    logic [SW-1:0] sum_s;

    // Magnitude add or subtract; the big operand never goes below the small one.
    always_comb begin
        if (s1_eff_sub_q) begin
            sum_s = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        end else begin
            sum_s = {1'b0, s1_big_q} + {1'b0, s1_small_q};
        end
    end

    logic               s2_valid_q, s2_spec_q, s2_inv_q, s2_sign_q, s2_zsign_q;
    logic [W-1:0]       s2_spec_res_q;
    logic [EXP_W-1:0]   s2_exp_q;
    logic [SW-1:0]      s2_sum_q;

    // Capture the raw sum with its sign, exponent and bypass information.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_inv_q      <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zsign_q    <= 1'b0;
            s2_spec_res_q <= {W{1'b0}};
            s2_exp_q      <= {EXP_W{1'b0}};
            s2_sum_q      <= {SW{1'b0}};
        end else if (adv_s) begin
            s2_valid_q    <= s1_valid_q;
            s2_spec_q     <= s1_spec_q;
            s2_inv_q      <= s1_inv_q;
            s2_sign_q     <= s1_sign_q;
            s2_zsign_q    <= s1_zsign_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= sum_s;
        end
    end

    // ---------------- stage 3 ----------------
    logic [LZW-1:0]          lzc_s;
    logic [FW-1:0]           norm_s;
    logic signed [XW-1:0]    exp_n_s, exp_r_s;
    logic [MANT_W:0]         sig_s;
    logic [MANT_W+1:0]       rnd_s;
    logic                    inc_s;
    logic [MANT_W-1:0]       mant_o_s;
    logic [W-1:0]            res_s;
    logic                    ovf_s, unf_s, inv_s;

    // Normalise, round, then pack with overflow/underflow/special handling.
    always_comb begin
        lzc_s = lzc_f(s2_sum_q[FW-1:0]);
        if (s2_sum_q[SW-1]) begin
            norm_s  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n_s = $signed({{(XW-EXP_W){1'b0}}, s2_exp_q}) + ONE_X;
        end else begin
            norm_s  = s2_sum_q[FW-1:0] << lzc_s;
            exp_n_s = $signed({{(XW-EXP_W){1'b0}}, s2_exp_q}) - $signed({{(XW-LZW){1'b0}}, lzc_s});
        end
        sig_s = norm_s[FW-1:3];
        inc_s = RNE_EN & norm_s[2] & (norm_s[1] | norm_s[0] | sig_s[0]);
        rnd_s = {1'b0, sig_s} + {{(MANT_W+1){1'b0}}, inc_s};
        if (rnd_s[MANT_W+1]) begin
            mant_o_s = {MANT_W{1'b0}};
            exp_r_s  = exp_n_s + ONE_X;
        end else begin
            mant_o_s = rnd_s[MANT_W-1:0];
            exp_r_s  = exp_n_s;
        end
        ovf_s = 1'b0;
        unf_s = 1'b0;
        inv_s = 1'b0;
        if (s2_spec_q) begin
            res_s = s2_spec_res_q;
            inv_s = s2_inv_q;
        end else if (s2_sum_q == {SW{1'b0}}) begin
            res_s = {s2_zsign_q, {(W-1){1'b0}}};
        end else if (exp_r_s >= EXP_MAX_X) begin
            res_s = {s2_sign_q, EXP_ONES, {MANT_W{1'b0}}};
            ovf_s = 1'b1;
        end else if (exp_r_s <= ZERO_X) begin
            res_s = {s2_sign_q, {(W-1){1'b0}}};
            unf_s = 1'b1;
        end else begin
            res_s = {s2_sign_q, exp_r_s[EXP_W-1:0], mant_o_s};
        end
    end

    logic [W-1:0] sum_q;
    logic         ovf_q, unf_q, inv_q;

    // Output register: loads only on a real result and holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= {W{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else if (adv_s) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                sum_q <= res_s;
                ovf_q <= ovf_s;
                unf_q <= unf_s;
                inv_q <= inv_s;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_add_float_pipe.sv
// Self-checking bench for add_float_pipe (binary32 defaults), scoreboard based.
module tb_add_float_pipe;

    typedef logic [34:0] exp_t;   // {sum, overflow, underflow, invalid}

    logic        clk;
    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic        overflow, underflow, invalid;
    logic [31:0] a, b, sum;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

`ifdef ADD_FLOAT_RNE_EN
    localparam logic [31:0] RND_RES = 32'h3F800001;
`else
    localparam logic [31:0] RND_RES = 32'h3F800000;
`endif

    localparam int NV = 14;
    localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF,
                                         32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h00C00000,
                                         32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h80000000,
                                         32'h7F800000, 32'h3F800000};
    localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF,
                                         32'hFF800000, 32'h33C00000, 32'h33800000, 32'h00800000,
                                         32'h3F800000, 32'h00000000, 32'h40000000, 32'h00000000,
                                         32'h7F800000, 32'hBF800000};
    localparam logic        VS [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam exp_t        VE [NV] = '{{32'h40400000, 3'b000}, {32'h00000000, 3'b000},
                                         {32'h80000000, 3'b000}, {32'h7F800000, 3'b100},
                                         {32'h7FC00000, 3'b001}, {RND_RES,      3'b000},
                                         {32'h3F800000, 3'b000}, {32'h00000000, 3'b010},
                                         {32'h7F800000, 3'b000}, {32'h7FC00000, 3'b001},
                                         {32'hBF800000, 3'b000}, {32'h80000000, 3'b000},
                                         {32'h7FC00000, 3'b001}, {32'h00000000, 3'b000}};

    localparam logic [31:0] BA [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                                        32'h3F000000, 32'h3FC00000, 32'h41200000, 32'hBF800000};
    localparam logic [31:0] BB [8] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000,
                                        32'h3F000000, 32'h3E800000, 32'h40C00000, 32'hBF800000};
    localparam logic        BS [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] BE [8] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'hBF800000,
                                        32'h3F800000, 32'h3FE00000, 32'h41800000, 32'hC0000000};

    add_float_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if ({sum, overflow, underflow, invalid} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {sum, overflow, underflow, invalid});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        int   lat;
        exp_t e;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a = VA[i]; b = VB[i]; sub = VS[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready);
            end
            sb_q.push_back(VE[i]);
            @(posedge clk);
            @(negedge clk); in_valid = 1'b0; #1;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                @(posedge clk); lat++;
                @(negedge clk); #1;
            end
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL vec%0d_latency got %0d want 3", i, lat);
            end
            checks++;
            if (out_valid !== 1'b1 || sb_q.size() == 0) begin
                errors++; $display("FAIL vec%0d_timeout got out_valid %b want 1", i, out_valid);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                if ({sum, overflow, underflow, invalid} !== e) begin
                    errors++;
                    $display("FAIL vec%0d_result got sum %h ovf/unf/inv %b want sum %h ovf/unf/inv %b",
                             i, sum, {overflow, underflow, invalid}, e[34:3], e[2:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   done = 0;
        int   cyc = 0;
        int   extra = 0;
        logic stall_prev = 1'b0;
        exp_t held = 35'd0;
        exp_t got;
        exp_t e;
        while (done < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0) ? 1'b1 : 1'b0;
            in_valid  = (sent < 8) ? 1'b1 : 1'b0;
            if (sent < 8) begin
                a = BA[sent]; b = BB[sent]; sub = BS[sent];
            end
            #1;
            got = {sum, overflow, underflow, invalid};
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready cyc%0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || got !== held) begin
                    errors++; $display("FAIL bp_hold cyc%0d got %h/%b want %h/1", cyc, got, out_valid, held);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra cyc%0d got %h want none", cyc, sum);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        errors++; $display("FAIL bp_result%0d got %h want %h", done, got, e);
                    end
                end
                done++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back({BE[sent], 3'b000});
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held = got;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (done !== 8) begin
            errors++; $display("FAIL bp_count got %0d want 8", done);
        end
        repeat (5) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || sb_q.size() !== 0) begin
            errors++; $display("FAIL bp_drain got extra %0d pending %0d want 0 0", extra, sb_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int   stale = 0;
        int   lat;
        exp_t e;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h40000000; b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || {sum, overflow, underflow, invalid} !== 35'd0) begin
            errors++; $display("FAIL midrst_clear got %b/%h want 0/0", out_valid, {sum, overflow, underflow, invalid});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++; $display("FAIL midrst_stale got %0d want 0", stale);
        end
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        sb_q.push_back({32'h40800000, 3'b000});
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0; #1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); lat++;
            @(negedge clk); #1;
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL midrst_latency got %0d want 3", lat);
        end
        checks++;
        if (out_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++; $display("FAIL midrst_timeout got out_valid %b want 1", out_valid);
        end else begin
            e = sb_q.pop_front();
            if ({sum, overflow, underflow, invalid} !== e) begin
                errors++; $display("FAIL midrst_result got %h want %h", {sum, overflow, underflow, invalid}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_float_pipe.md
# add_float_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the processing element. Exponent and mantissa widths are configurable, and the default is binary32. It accepts one operand pair per cycle under a valid/ready handshake and produces a normalised, rounded result after three stages. It is the clocked, backpressure-aware successor to the combinational single-precision adder, and it adds subtract mode, special-value handling and exception flags.

## Interface
- `EXP_W`, default 8: exponent field width; legal range 4..11.
- `MANT_W`, default 23: stored mantissa width, hidden bit excluded; legal range 8..52.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: operand pair presented.
- `in_ready`, output, 1: stage 1 accepts this cycle.
- `a`, `b`, input, `1+EXP_W+MANT_W` each: operands.
- `sub`, input, 1: 1 computes a−b; 0 computes a+b.
- `out_valid`, output, 1: result presented.
- `out_ready`, input, 1: downstream accepts.
- `sum`, output, `1+EXP_W+MANT_W`: result.
- `overflow`, output, 1: finite operands produced ±inf.
- `underflow`, output, 1: nonzero exact result flushed to zero.
- `invalid`, output, 1: NaN produced (inf−inf or NaN input).

## Operation
**Stage 1, unpack and align**
- Effective b sign = `b.sign ^ sub`.
- Operands with exp==0 are flush-to-zero.
- exp==all-ones means inf (mant==0) or NaN (mant!=0).
- Swap the operands so the larger magnitude (exp, then mant) is the first operand.
- exp_diff = exp_big − exp_small.
- Shift the small significand `{1,mant}` right by exp_diff into a field that is MANT_W+4 bits wide, carrying guard, round and sticky.
- If exp_diff ≥ MANT_W+3, the small operand becomes sticky only.

**Stage 2, add**
- Same effective signs: add magnitudes. Otherwise: subtract small from big.
- Result sign = sign of the big operand.
- Sum field is MANT_W+5 bits, including the carry.

**Stage 3, normalise, round and pack**
- On carry: shift right 1 and increment the exponent.
- Otherwise: leading-zero count, then shift left and decrement the exponent by the count.
- Rounding is per Configuration. A rounding carry renormalises (exp+1).
- Biased exponent ≥ all-ones: output ±inf, `overflow`=1.
- Biased exponent ≤ 0 with a nonzero magnitude: output ±0, `underflow`=1.
- Exact cancellation gives +0. Both operands zero gives a negative sign only if both effective signs are negative.

**Special values**
- Specials bypass the arithmetic through a stage-1 flag carried down the pipe.
- Any NaN input, or inf plus an opposite-signed inf, outputs canonical quiet NaN (sign 0, exp all-ones, mant MSB 1, rest 0) with `invalid`=1.
- inf plus a finite value outputs that inf with no flags.

## Timing
- Latency: 3 cycles from input acceptance to `out_valid`, with no stall.
- Throughput: one result per cycle.
- Global advance `adv = !out_valid || out_ready`; all stage registers update only when `adv`=1.
- `in_ready = adv && rst_n`, combinational.
- A transfer happens on a rising edge with valid && ready on the respective side.
- While stalled, `sum` and the flags are held stable.
- Bubbles advance with `adv`; no bubble collapsing.
- Reset (`rst_n`=0 at an edge): all stage-valid bits, `out_valid`, `sum`, `overflow`, `underflow` and `invalid` clear to 0. In-flight operations are discarded with no partial output. `in_ready`=0 while `rst_n`=0 and 1 on the first cycle after release.
- `out_valid` may be high while `out_ready` is low indefinitely. Data must not change until it is accepted.

## Configuration
- `ADD_FLOAT_RNE_EN` defined: round-to-nearest-even using guard, round and sticky. Increment when G && (R || S || lsb).
- Not defined: truncate (round toward zero). G, R and S are discarded, and a rounding carry never occurs.
- The flag and special-value behaviour is identical in both builds.

## Test plan
All values use the defaults. Operands are written as a, b.
- Add `3F800000`, `40000000` with `sub`=0 → `sum`=`40400000` on cycle 3, all flags 0.
- Subtract `3F800000`, `3F800000` with `sub`=1 → `sum`=`00000000`. Then add `80000000`, `80000000` → `80000000`.
- Add `7F7FFFFF`, `7F7FFFFF` → `7F800000`, `overflow`=1. Add `7F800000`, `FF800000` → `7FC00000`, `invalid`=1.
- Add `3F800000`, `33C00000` → `3F800001` with RNE_EN; `3F800000` without. Add `3F800000`, `33800000` (a tie) → `3F800000` in both builds.
- Backpressure: stream 8 back-to-back pairs with `out_ready` toggling 1,0,0,1… → all 8 results in order, no loss or duplication, `sum` stable while stalled, `in_ready` low exactly when `out_valid`=1 and `out_ready`=0.
- Reset mid-stream: 2 operations in flight, `rst_n`=0 for one cycle → `out_valid`=0 and outputs 0 the next cycle, no stale result ever appears, and a new op after release returns after 3 cycles.
